// File: rtl/pl2bram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pl2bram_pkg : shared types and constants for the PL2BRAM write path   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package pl2bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int         WORD_BYTES  = 4;
  localparam logic [3:0] BRAM_WE_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/pl2bram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pl2bram_writer : AXI4-Stream to BRAM port A write engine              |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module pl2bram_writer
  import pl2bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  word_cnt,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  busy,
  output logic                  done,
  output logic                  err_short,
  output logic                  err_long,
  output logic [LEN_WIDTH-1:0]  words_done
);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_word_cnt;
  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_unused;

  // Byte-lane bits of the base address are dropped: transfers are word aligned.
  assign w_unused      = ^base_addr[1:0];

  assign s_axis_tready = (r_state == ST_RUN);
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_FINISH);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_last_word   = ((words_done + LEN_WIDTH'(1)) == r_word_cnt);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = (word_cnt == '0) ? ST_FINISH : ST_RUN;
      ST_RUN:    if (w_accept && (s_axis_tlast || w_last_word)) w_state_next = ST_FINISH;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_word_cnt <= '0;
      bram_en    <= 1'b0;
      bram_we    <= '0;
      bram_addr  <= '0;
      bram_din   <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      words_done <= '0;
    end else begin
      r_state <= w_state_next;
      bram_en <= 1'b0;
      bram_we <= '0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr     <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
            r_word_cnt <= word_cnt;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            words_done <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            bram_en    <= 1'b1;
            bram_we    <= BRAM_WE_ALL;
            bram_addr  <= r_addr;
            bram_din   <= s_axis_tdata;
            // Wraps naturally at the top of BRAM.
            r_addr     <= r_addr + ADDR_WIDTH'(WORD_BYTES);
            words_done <= words_done + LEN_WIDTH'(1);
            if (s_axis_tlast && !w_last_word) err_short <= 1'b1;
            if (!s_axis_tlast && w_last_word) err_long  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pl2bram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pl2bram_writer : randomized directed bench for pl2bram_writer      |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_pl2bram_writer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [12:0] base_addr;
  logic [11:0] word_cnt;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [12:0] bram_addr;
  logic [31:0] bram_din;
  logic        busy;
  logic        done;
  logic        err_short;
  logic        err_long;
  logic [11:0] words_done;

  pl2bram_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(13), .LEN_WIDTH(12)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .busy(busy),
    .done(done), .err_short(err_short), .err_long(err_long), .words_done(words_done)
  );

  always #5 ACLK = ~ACLK;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit mon_on  = 0;

  // Observed BRAM writes and done pulses
  logic [12:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cnt;
  int          done_cyc;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge ACLK) begin
    if (mon_on) begin
      if (bram_en === 1'b1) begin
        check("we_on_write", {28'd0, bram_we}, 32'hF);
        wr_addr.push_back(bram_addr);
        wr_data.push_back(bram_din);
        wr_cyc.push_back(cyc);
      end else if (bram_we !== 4'h0) begin
        check("we_idle", {28'd0, bram_we}, 32'h0);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd0);
    check({tag, "_en"}, {31'd0, bram_en}, 32'd0);
    check({tag, "_we"}, {28'd0, bram_we}, 32'd0);
    check({tag, "_addr"}, {19'd0, bram_addr}, 32'd0);
    check({tag, "_din"}, bram_din, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_eshort"}, {31'd0, err_short}, 32'd0);
    check({tag, "_elong"}, {31'd0, err_long}, 32'd0);
    check({tag, "_words"}, {20'd0, words_done}, 32'd0);
  endtask

  // vmode: 0 continuous, 1 every other cycle, 2 random
  task automatic run_xfer(input string tag, input logic [12:0] base, input logic [11:0] cnt,
                          input int pkt_len, input int vmode, input bit restart_mid);
    logic [31:0] pkt[$];
    int acc_cyc[$];
    int n_exp, idx, k, start_cyc, exp_addr;
    bit exp_short, exp_long;

    for (int i = 0; i < pkt_len; i++) pkt.push_back($urandom);
    // Reference: words written stop at the earlier of tlast and the word count
    n_exp     = (int'(cnt) < pkt_len) ? int'(cnt) : pkt_len;
    exp_short = (cnt != 0) && (pkt_len < int'(cnt));
    exp_long  = (cnt != 0) && (pkt_len > int'(cnt));

    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cnt = 0; done_cyc = -1;

    start = 1'b1; base_addr = base; word_cnt = cnt; start_cyc = cyc;
    tick();
    start = 1'b0;
    check({tag, "_busy_n1"}, {31'd0, busy}, 32'd1);
    check({tag, "_tready_n1"}, {31'd0, s_axis_tready}, {31'd0, cnt != 0});

    idx = 0; k = 0;
    while (idx < pkt_len && busy && k < 400) begin
      case (vmode)
        0:       s_axis_tvalid = 1'b1;
        1:       s_axis_tvalid = (k % 2 == 0);
        default: s_axis_tvalid = 1'($urandom_range(0, 1));
      endcase
      s_axis_tdata = pkt[idx];
      s_axis_tlast = (idx == pkt_len - 1);
      if (restart_mid && k == 3) begin
        start = 1'b1; base_addr = base ^ 13'h040; word_cnt = cnt + 12'd3;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      tick();
      start = 1'b0;
      k++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    for (int j = 0; j < 10 && busy; j++) tick();
    tick();

    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_accepted"}, idx, n_exp);
    check({tag, "_nwrites"}, wr_addr.size(), n_exp);
    for (int i = 0; i < n_exp && i < wr_addr.size(); i++) begin
      exp_addr = ((int'(base) & 'h1FFC) + 4 * i) % 8192;
      check({tag, "_addr"}, {19'd0, wr_addr[i]}, exp_addr);
      check({tag, "_data"}, wr_data[i], pkt[i]);
      check({tag, "_wr_cyc"}, wr_cyc[i], acc_cyc[i] + 1);
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, (n_exp > 0) ? acc_cyc[n_exp-1] + 1 : start_cyc + 1);
    check({tag, "_err_short"}, {31'd0, err_short}, {31'd0, exp_short});
    check({tag, "_err_long"}, {31'd0, err_long}, {31'd0, exp_long});
    check({tag, "_words_done"}, {20'd0, words_done}, n_exp);
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    ARESET = 1'b0;
    mon_on = 1'b1;
    tick();

    run_xfer("basic",   13'h000, 12'd4, 4, 0, 1'b0);
    run_xfer("toggle",  13'h100, 12'd8, 8, 1, 1'b0);
    run_xfer("short",   13'h040, 12'd6, 3, 0, 1'b0);
    run_xfer("long",    13'h080, 12'd2, 4, 0, 1'b0);
    run_xfer("wrap",    13'h1FF8, 12'd4, 4, 0, 1'b0);
    run_xfer("zero",    13'h020, 12'd0, 0, 0, 1'b0);
    run_xfer("restart", 13'h300, 12'd8, 8, 0, 1'b1);
    run_xfer("unalign", 13'h123, 12'd3, 3, 2, 1'b0);
    for (int r = 0; r < 4; r++)
      run_xfer("rand", 13'($urandom_range(0, 8191)), 12'($urandom_range(1, 10)),
               $urandom_range(1, 12), 2, 1'b0);

    // Reset during the second beat of an 8-word transfer
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    start = 1'b1; base_addr = 13'h200; word_cnt = 12'd8;
    tick();
    start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA5A5_0001; s_axis_tlast = 1'b0;
    tick();
    s_axis_tdata = 32'hA5A5_0002;
    ARESET = 1'b1;
    tick();
    check_all_zero("midreset");
    ARESET = 1'b0;
    repeat (5) tick();
    s_axis_tvalid = 1'b0;
    tick();
    check("midreset_nwrites", wr_addr.size(), 1);
    check("midreset_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pl2bram_writer.md
# pl2bram_writer

PL-side write engine that sits directly downstream of the PL2BRAM AXI4-Lite register slave: it takes a start command (base address, word count) from the slave's control registers and streams 32-bit words from a PL AXI4-Stream source into BRAM port A. It reports busy/done/error status back into the slave's status registers, so software can program a transfer and poll for completion.

## Interface
- DATA_WIDTH, 32, stream and BRAM word width (fixed 32 in this release)
- ADDR_WIDTH, 13, BRAM byte-address width (8 KiB)
- LEN_WIDTH, 12, width of the word-count field
- ACLK  in  1  single clock; all logic rising-edge
- ARESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse from the register slave
- base_addr  in  ADDR_WIDTH  byte start address; bits [1:0] ignored (word aligned)
- word_cnt  in  LEN_WIDTH  number of words to write; sampled with start
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tlast  in  1  last beat of packet
- bram_en  out  1  BRAM port enable
- bram_we  out  4  byte write enables (all-ones or zero)
- bram_addr  out  ADDR_WIDTH  BRAM byte address
- bram_din  out  DATA_WIDTH  BRAM write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- err_short  out  1  sticky: tlast arrived before word_cnt words
- err_long  out  1  sticky: word_cnt reached without tlast
- words_done  out  LEN_WIDTH  words written in current/last transfer

## Operation
- FSM states IDLE, RUN, FINISH.
- IDLE: s_axis_tready=0. On start: latch base_addr (bits [1:0] forced 0) and word_cnt, clear err_short, err_long and words_done. Go to FINISH if word_cnt=0, else RUN.
- RUN: s_axis_tready=1.
  - Each accepted beat (tvalid&&tready): drive bram_en=1, bram_we=4'hF, bram_addr=current address, bram_din=tdata on the registered outputs; address += 4; words_done += 1.
  - Beat with tlast before the final word: set err_short, go FINISH.
  - Final word (words_done reaches word_cnt) without tlast: set err_long, go FINISH; the remaining packet beats are not accepted.
  - Final word with tlast: clean completion, go FINISH.
- FINISH: one cycle; done=1, then IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: a transfer crossing the top of BRAM wraps to 0 and does not flag an error.
- start while busy=1 is ignored; latched parameters do not change.
- busy=1 in RUN and FINISH.
- err_* and words_done hold their values until the next accepted start.

## Timing
- Reset values: s_axis_tready=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, err_short=0, err_long=0, words_done=0, FSM=IDLE.
- ARESET during RUN aborts the transfer: all outputs take reset values at the next edge, and no further BRAM writes occur.
- start in cycle N: busy=1 and tready=1 at cycle N+1.
- BRAM write: the beat accepted in cycle K appears on bram_* in cycle K+1. Writes are one cycle each and back-to-back at full rate.
- tready drops in the same cycle the FSM leaves RUN; the final beat's BRAM write overlaps the FINISH cycle.
- done pulses one cycle after the last accepted beat, or at N+1 for word_cnt=0.
- bram_en/bram_we are 0 in every cycle without a write.

## Structure
- Shared package pl2bram_pkg: FSM state enum, WORD_BYTES=4 constant, BRAM_WE_ALL=4'hF.
- Single flat module. No sub-module is needed; the FSM, address counter and write register are one always_ff block plus output logic.

## Test plan
- base=0x000, cnt=4, beats 1..4 with tlast on the 4th, tvalid continuous -> writes 1,2,3,4 at 0x0,0x4,0x8,0xC on consecutive cycles; done one cycle after beat 4; no errors; words_done=4.
- base=0x100, cnt=8, tvalid toggled every other cycle -> 8 writes at 0x100..0x11C only on accepted beats; done after the 8th.
- cnt=6, tlast on beat 3 -> 3 writes; err_short=1; words_done=3; done pulses.
- cnt=2, packet of 4 beats -> 2 writes; err_long=1; tready=0 for beats 3-4.
- base=0x1FF8, cnt=4 -> writes at 0x1FF8, 0x1FFC, 0x0000, 0x0004.
- cnt=0 -> done at N+1, no BRAM write. start pulsed mid-transfer -> ignored. ARESET asserted during beat 2 of 8 -> all outputs 0 next edge, no further writes.
